// File: rtl/serial_sub_pkg.sv
// Purpose : shared state encoding and sizing helper for the bit-serial subtractor.
// Latency : n/a (types and functions only).
// Backpr. : n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bit-counter width for a WIDTH-bit operation; counts 0..WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Purpose : 1-bit full subtractor, d = a - b - bin, built from two half subtractors.
// Latency : combinational.
// Backpr. : none.
// Ports   : a, b, bin in; d (difference), bout (borrow) out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d0;
    logic b0;
    logic b1;

    halfsubtractor u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d0),
        .bout (b0)
    );

    // Second stage subtracts the incoming borrow from the first-stage difference.
    halfsubtractor u_hs1 (
        .a    (d0),
        .b    (bin),
        .d    (d),
        .bout (b1)
    );

    assign bout = b0 | b1;

endmodule

// File: rtl/halfsubtractor.sv
// Purpose : 1-bit half subtractor, d = a - b with borrow out.
// Latency : combinational.
// Backpr. : none.
// Ports   : a, b in; d (difference), bout (borrow) out.
module halfsubtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Purpose : bit-serial unsigned A - B, LSB first, through one shared full-subtractor cell.
// Latency : accept edge, then WIDTH bit edges; res_valid rises the cycle after the last bit.
// Backpr. : start_ready only in IDLE; result held in DONE until res_ready, indefinitely.
// Ports   : clk, rst_n; start_valid/start_ready + a_in/b_in (operands);
//           res_valid/res_ready + diff_out/borrow_out (result); busy (RUN or DONE).
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_bit;
    logic             bit_d;
    logic             bit_bout;

    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign accept   = start_valid && (state == ST_IDLE);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result enters at the MSB and shifts right, so after WIDTH bits the
    // first-computed bit (LSB) has reached bit 0. Registers only move in RUN,
    // which keeps diff_out/borrow_out frozen while DONE waits on res_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (state == ST_RUN) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            res_sr   <= {bit_d, res_sr[WIDTH-1:1]};
            borrow_q <= bit_bout;
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign diff_out   = res_sr;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sv8, sr8, rv8, rr8, bw8, bz8;
    logic [7:0] a8, b8, d8;
    logic       sv2, sr2, rv2, rr2, bw2, bz2;
    logic [1:0] a2, b2, d2;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a_in(a8), .b_in(b8), .res_valid(rv8), .res_ready(rr8),
        .diff_out(d8), .borrow_out(bw8), .busy(bz8)
    );

    serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
        .a_in(a2), .b_in(b2), .res_valid(rv2), .res_ready(rr2),
        .diff_out(d2), .borrow_out(bw2), .busy(bz2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bw;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] aa, input logic [7:0] bb);
        if (s == 0) begin
            sv8 = v; a8 = aa; b8 = bb;
        end else begin
            sv2 = v; a2 = aa[1:0]; b2 = bb[1:0];
        end
    endtask

    task automatic set_rr(input int s, input logic r);
        if (s == 0) rr8 = r;
        else        rr2 = r;
    endtask

    function automatic logic rv_of(input int s);
        return (s == 0) ? rv8 : rv2;
    endfunction
    function automatic logic sr_of(input int s);
        return (s == 0) ? sr8 : sr2;
    endfunction
    function automatic logic bz_of(input int s);
        return (s == 0) ? bz8 : bz2;
    endfunction
    function automatic logic bw_of(input int s);
        return (s == 0) ? bw8 : bw2;
    endfunction
    function automatic logic [7:0] d_of(input int s);
        return (s == 0) ? d8 : {6'b0, d2};
    endfunction

    // Reference: plain integer subtraction of the masked operands.
    task automatic model(input int s, input logic [7:0] aa, input logic [7:0] bb,
                         output logic [7:0] ed, output logic ebw);
        logic [7:0] m;
        int         x;
        m   = (s == 0) ? 8'hFF : 8'h03;
        x   = int'(aa & m) - int'(bb & m);
        ebw = (x < 0);
        ed  = 8'(x) & m;
    endtask

    task automatic check_idle(input string tag, input int s);
        chk({tag, "_start_ready"}, sr_of(s), 1);
        chk({tag, "_res_valid"},   rv_of(s), 0);
        chk({tag, "_busy"},        bz_of(s), 0);
    endtask

    // Starts at a negedge with the DUT idle; returns at a negedge after the handshake.
    task automatic run_op(input int s, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [7:0] ed, input logic ebw, input int hold);
        int lat;
        int w;
        w = (s == 0) ? 8 : 2;
        chk("ready_before_op", sr_of(s), 1);
        drive(s, 1'b1, aa, bb);
        @(negedge clk);
        chk("busy_after_accept", bz_of(s), 1);
        drive(s, 1'b0, 8'($urandom), 8'($urandom));
        lat = 0;
        while (!rv_of(s) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, w);
        repeat (hold) begin
            chk("hold_diff", d_of(s), ed);
            chk("hold_valid", rv_of(s), 1);
            @(negedge clk);
        end
        chk("diff", d_of(s), ed);
        chk("borrow", bw_of(s), ebw);
        set_rr(s, 1'b1);
        @(negedge clk);
        set_rr(s, 1'b0);
        chk("valid_drop", rv_of(s), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ed;
        logic       ebw;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hAA, 8'h55, 8'h55, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst_n = 1'b0;
        sv8 = 0; rr8 = 0; a8 = 0; b8 = 0;
        sv2 = 0; rr2 = 0; a2 = 0; b2 = 0;
        #2;
        for (int s = 0; s < 2; s++) begin
            check_idle("reset", s);
            chk("reset_diff", d_of(s), 0);
            chk("reset_borrow", bw_of(s), 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, WIDTH=8
        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bw, 0);
        end

        // Backpressure: 0x12 - 0x34 = 0xDE with borrow; start_valid held high meanwhile
        drive(0, 1'b1, 8'h12, 8'h34);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 40 && !rv8; k++) @(negedge clk);
        drive(0, 1'b1, 8'hFF, 8'h00);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rv8, 1);
            chk("bp_ready", sr8, 0);
            chk("bp_busy", bz8, 1);
            chk("bp_diff", d8, 8'hDE);
            chk("bp_borrow", bw8, 1);
            @(negedge clk);
        end
        chk("bp_diff_end", d8, 8'hDE);
        drive(0, 1'b0, 8'h00, 8'h00);
        rr8 = 1'b1;
        @(negedge clk);
        rr8 = 1'b0;
        check_idle("bp_after", 0);

        // Back-to-back: start_valid and res_ready held high across two operations
        drive(0, 1'b1, 8'h40, 8'h10);
        rr8 = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a8 = 8'h05;
                b8 = 8'h09;
                chk("b2b_busy1", bz8, 1);
            end
            if (i >= 2 && i <= 8) chk("b2b_no_valid", rv8, 0);
            if (i == 9) begin
                chk("b2b_valid1", rv8, 1);
                chk("b2b_diff1", d8, 8'h30);
                chk("b2b_borrow1", bw8, 0);
            end
            if (i == 10) check_idle("b2b_gap", 0);
            if (i == 11) begin
                chk("b2b_busy2", bz8, 1);
                chk("b2b_ready2", sr8, 0);
                sv8 = 1'b0;
            end
            if (i == 19) begin
                chk("b2b_valid2", rv8, 1);
                chk("b2b_diff2", d8, 8'hFC);
                chk("b2b_borrow2", bw8, 1);
            end
        end
        @(negedge clk);
        rr8 = 1'b0;
        check_idle("b2b_after", 0);

        // Reset after four bits of 0x10 - 0x0F (partial borrow/diff nonzero)
        drive(0, 1'b1, 8'h10, 8'h0F);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("midrst", 0);
        chk("midrst_diff", d8, 0);
        chk("midrst_borrow", bw8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst_no_valid", rv8, 0);
        end
        run_op(0, 8'hAA, 8'h55, 8'h55, 1'b0, 0);

        // Exhaustive sweep at WIDTH=2
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                ea = 8'(x);
                eb = 8'(y);
                model(1, ea, eb, ed, ebw);
                run_op(1, ea, eb, ed, ebw, 0);
            end
        end

        // Random traffic on both widths
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 1000; n++) begin
                ea = 8'($urandom);
                eb = 8'($urandom);
                model(s, ea, eb, ed, ebw);
                run_op(s, ea, eb, ed, ebw, $urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
